pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter / branch-resolution stage sitting directly downstream of the instruction decoder.
- Consumes the decoder's 4-bit pcControl code and the 21-bit op2 field as jump target.
- Holds the architectural compare flags written by ALU operations and resolves conditional jumps against them.
- Produces the fetch address for instruction memory, a halt status, a branch-taken pulse for fetch flush and a retired-instruction counter.

Parameters:
- PC_WIDTH, 21, width of pc and target; matches the op2 field.
- RESET_PC, 0, pc value after reset.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pcControl  in  4  decoder jump code.
- target  in  PC_WIDTH  jump destination (decoder op2).
- stall  in  1  1 = freeze the whole unit this cycle.
- alu_we  in  1  1 = current instruction writes compare flags.
- alu_equal  in  1  ALU result: operands equal.
- alu_below  in  1  ALU result: op1 < op2, unsigned.
- alu_zero  in  1  ALU result is zero.
- pc  out  PC_WIDTH  current fetch address.
- halted  out  1  1 = HLT executed; unit frozen.
- branch_taken  out  1  registered one-cycle pulse: pc was loaded from target.
- flags  out  3  registered {zero, below, equal}.
- icount  out  CNT_WIDTH  retired-instruction count, saturating.

Behaviour:
- Reset (async, resetn=0): pc=RESET_PC, halted=0, branch_taken=0, flags=3'b000, icount=0, state=RUN. Reset asserted mid-operation overrides everything immediately, including HALT.
- States: RUN, HALT. RUN→HALT on pcControl=10 when not stalled. HALT exits only by reset.
- In HALT: pc, flags and icount hold. branch_taken=0. halted=1 from the cycle after HLT is accepted.
- Stall in RUN: pc, flags, icount and state hold; branch_taken=0.
- Per accepted cycle (RUN, stall=0), branch condition uses the registered flags (old values), not same-cycle alu_* inputs:
  - 0 sequential
  - 1 JE: equal
  - 2 JB: below
  - 3 JA: !below & !equal
  - 4 JNE: !equal
  - 5 JBE: below | equal
  - 6 JAE: !below
  - 7 JNZ: !zero
  - 8 JZ: zero
  - 9 JMP: unconditional
  - 10 HLT
  - 11–15: treated as sequential, no error.
- Next pc:
  - taken → target; branch_taken=1 next cycle.
  - HLT → pc holds (points at the HLT).
  - otherwise → pc+1, modulo 2^PC_WIDTH; the maximum value wraps to 0.
- Flag update: if alu_we=1 on an accepted cycle, flags <= {alu_zero, alu_below, alu_equal} at the clock edge. If alu_we and a conditional jump occur in the same cycle, the jump evaluates the old flags.
- icount: +1 per accepted cycle, HLT included. Saturates at all-ones.
- Latency: a jump resolves in the same cycle; the new pc is visible one clock later. No delay slot is mandated here; fetch flush uses branch_taken.

Decomposition:
- Shared package cpu_pkg holds:
  - pcControl codes: PC_SEQ=0, PC_JE=1, PC_JB=2, PC_JA=3, PC_JNE=4, PC_JBE=5, PC_JAE=6, PC_JNZ=7, PC_JZ=8, PC_JMP=9, PC_HLT=10.
  - Flag bit indices: FLAG_EQ=0, FLAG_BELOW=1, FLAG_ZERO=2.
  - State encoding: RUN, HALT.
- One sub-module: branch_cond. Purely combinational; pcControl + flags → take. It is reused by the verification scoreboard.

Test Plan:
- Reset with RESET_PC=0 → pc=0, flags=0, icount=0. Hold pcControl=0 for 5 cycles → pc=5, icount=5, branch_taken never asserted.
- alu_we=1, alu_equal=1; next cycle pcControl=1, target=0x00100 → pc=0x00100 one clock later, branch_taken=1 for exactly one cycle. Repeat with equal=0 → pc increments.
- Same cycle alu_we=1 (equal=1) and pcControl=1, with flags previously 0 → jump not taken. A following JE is taken.
- Load pc=0x1FFFFF via JMP, then pcControl=0 → pc=0x000000.
- pcControl=10 at pc=7 → halted=1, pc stays 7 for 20 cycles while pcControl=9 is applied. Pulse resetn low → pc=0, halted=0 asynchronously.
- stall=1 for 3 cycles during JMP, target=0x42 → pc and icount frozen. On stall=0, pc=0x42 one cycle later.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions: decoder pcControl codes, compare-flag
//               bit positions and the pc_unit state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Jump codes produced by the instruction decoder
    localparam logic [3:0] PC_SEQ = 4'd0;
    localparam logic [3:0] PC_JE  = 4'd1;
    localparam logic [3:0] PC_JB  = 4'd2;
    localparam logic [3:0] PC_JA  = 4'd3;
    localparam logic [3:0] PC_JNE = 4'd4;
    localparam logic [3:0] PC_JBE = 4'd5;
    localparam logic [3:0] PC_JAE = 4'd6;
    localparam logic [3:0] PC_JNZ = 4'd7;
    localparam logic [3:0] PC_JZ  = 4'd8;
    localparam logic [3:0] PC_JMP = 4'd9;
    localparam logic [3:0] PC_HLT = 4'd10;

    // Bit positions inside the 3-bit flags vector {zero, below, equal}
    localparam int FLAG_EQ    = 0;
    localparam int FLAG_BELOW = 1;
    localparam int FLAG_ZERO  = 2;

    // Program-counter unit run state
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational jump-condition evaluator. Decides whether the
//               decoder's pcControl code is taken given the compare flags.
//               HLT and the unused codes are never taken.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import cpu_pkg::*;
(
    input  logic [3:0] pcControl,
    input  logic [2:0] flags,
    output logic       take
);

    logic w_eq;
    logic w_below;
    logic w_zero;

    assign w_eq    = flags[FLAG_EQ];
    assign w_below = flags[FLAG_BELOW];
    assign w_zero  = flags[FLAG_ZERO];

    // Map each jump code to its flag condition
    always_comb begin
        take = 1'b0;
        case (pcControl)
            PC_JE:   take = w_eq;
            PC_JB:   take = w_below;
            PC_JA:   take = ~w_below & ~w_eq;
            PC_JNE:  take = ~w_eq;
            PC_JBE:  take = w_below | w_eq;
            PC_JAE:  take = ~w_below;
            PC_JNZ:  take = ~w_zero;
            PC_JZ:   take = w_zero;
            PC_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule : branch_cond
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter and branch resolution stage. Holds the
//               compare flags, resolves jumps against the registered (old)
//               flags, tracks halt state and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = 21,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned          CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [3:0]           pcControl,
    input  logic [PC_WIDTH-1:0]  target,
    input  logic                 stall,
    input  logic                 alu_we,
    input  logic                 alu_equal,
    input  logic                 alu_below,
    input  logic                 alu_zero,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 halted,
    output logic                 branch_taken,
    output logic [2:0]           flags,
    output logic [CNT_WIDTH-1:0] icount
);

    localparam logic [PC_WIDTH-1:0]  c_pc_one  = PC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    pc_state_t              r_state;
    pc_state_t              w_state_next;
    logic                   w_accept;
    logic                   w_take;

    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    w_pc_next;
    logic [2:0]             r_flags;
    logic [2:0]             w_flags_next;
    logic [CNT_WIDTH-1:0]   r_icount;
    logic [CNT_WIDTH-1:0]   w_icount_next;
    logic                   r_branch;
    logic                   w_branch_next;

    // Condition uses the registered flags so a same-cycle ALU write is not seen
    branch_cond u_branch_cond (
        .pcControl (pcControl),
        .flags     (r_flags),
        .take      (w_take)
    );

    // Run/halt state register; only reset leaves HALT
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and accept qualifier: an instruction retires only in RUN without stall
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            RUN: begin
                w_accept = ~stall;
                if (!stall && (pcControl == PC_HLT)) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // Next-value logic for pc, flags, counter and the branch pulse
    always_comb begin
        w_pc_next     = r_pc;
        w_flags_next  = r_flags;
        w_icount_next = r_icount;
        w_branch_next = 1'b0;
        if (w_accept) begin
            if (r_icount != {CNT_WIDTH{1'b1}}) begin
                w_icount_next = r_icount + c_cnt_one;
            end
            if (alu_we) begin
                w_flags_next = {alu_zero, alu_below, alu_equal};
            end
            if (pcControl == PC_HLT) begin
                // pc keeps pointing at the HLT instruction
                w_pc_next = r_pc;
            end else if (w_take) begin
                w_pc_next     = target;
                w_branch_next = 1'b1;
            end else begin
                // Natural wrap from all-ones back to zero
                w_pc_next = r_pc + c_pc_one;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc     <= RESET_PC;
            r_flags  <= 3'b000;
            r_icount <= '0;
            r_branch <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_flags  <= w_flags_next;
            r_icount <= w_icount_next;
            r_branch <= w_branch_next;
        end
    end

    assign pc           = r_pc;
    assign halted       = (r_state == HALT);
    assign branch_taken = r_branch;
    assign flags        = r_flags;
    assign icount       = r_icount;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit: directed scenarios followed
//               by randomized traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int PW = 21;
    localparam int CW = 8;
    localparam int unsigned PC_MOD  = 32'h0020_0000;
    localparam int unsigned CNT_MAX = 255;

    logic          clock = 1'b0;
    logic          resetn;
    logic [3:0]    pcControl;
    logic [PW-1:0] target;
    logic          stall;
    logic          alu_we;
    logic          alu_equal;
    logic          alu_below;
    logic          alu_zero;
    logic [PW-1:0] pc;
    logic          halted;
    logic          branch_taken;
    logic [2:0]    flags;
    logic [CW-1:0] icount;

    pc_unit #(
        .PC_WIDTH  (PW),
        .RESET_PC  ('0),
        .CNT_WIDTH (CW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pcControl    (pcControl),
        .target       (target),
        .stall        (stall),
        .alu_we       (alu_we),
        .alu_equal    (alu_equal),
        .alu_below    (alu_below),
        .alu_zero     (alu_zero),
        .pc           (pc),
        .halted       (halted),
        .branch_taken (branch_taken),
        .flags        (flags),
        .icount       (icount)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int unsigned m_pc;
    int unsigned m_icount;
    bit          m_halted;
    bit          m_bt;
    bit          m_eq;
    bit          m_below;
    bit          m_zero;

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk_value({tag, ".pc"},     64'(pc),           64'(m_pc));
        chk_value({tag, ".halted"}, 64'(halted),       64'(m_halted));
        chk_value({tag, ".bt"},     64'(branch_taken), 64'(m_bt));
        chk_value({tag, ".flags"},  64'(flags),        64'({m_zero, m_below, m_eq}));
        chk_value({tag, ".icount"}, 64'(icount),       64'(m_icount));
    endtask

    task automatic model_reset();
        m_pc     = 0;
        m_icount = 0;
        m_halted = 1'b0;
        m_bt     = 1'b0;
        m_eq     = 1'b0;
        m_below  = 1'b0;
        m_zero   = 1'b0;
    endtask

    // Jump decision from the architectural rule table
    function automatic bit model_take(input int code);
        case (code)
            1:       return m_eq;
            2:       return m_below;
            3:       return !m_below && !m_eq;
            4:       return !m_eq;
            5:       return m_below || m_eq;
            6:       return !m_below;
            7:       return !m_zero;
            8:       return m_zero;
            9:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle, advance the model across the edge, then compare
    task automatic step(input int code, input int unsigned tgt, input bit st,
                        input bit we, input bit eq, input bit bl, input bit zr,
                        input string tag);
        bit tk;
        pcControl = 4'(code);
        target    = PW'(tgt);
        stall     = st;
        alu_we    = we;
        alu_equal = eq;
        alu_below = bl;
        alu_zero  = zr;
        @(posedge clock);
        if (!m_halted && !st) begin
            tk   = model_take(code);
            m_bt = tk;
            if (code == 10)  m_halted = 1'b1;
            else if (tk)     m_pc = tgt % PC_MOD;
            else             m_pc = (m_pc + 1) % PC_MOD;
            if (we) begin
                m_eq    = eq;
                m_below = bl;
                m_zero  = zr;
            end
            if (m_icount < CNT_MAX) m_icount++;
        end else begin
            m_bt = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse asserted between clock edges
    task automatic apply_reset(input string tag);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int code;
        resetn    = 1'b0;
        pcControl = '0;
        target    = '0;
        stall     = 1'b0;
        alu_we    = 1'b0;
        alu_equal = 1'b0;
        alu_below = 1'b0;
        alu_zero  = 1'b0;
        #12;
        model_reset();
        check_all("reset");
        @(negedge clock);
        resetn = 1'b1;

        // Sequential run
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, "seq");
        chk_value("seq5.pc", 64'(pc), 64'd5);

        // JE taken after flag write, then not taken with equal cleared
        step(0, 0, 0, 1, 1, 0, 0, "we_eq1");
        step(1, 32'h100, 0, 0, 0, 0, 0, "je_taken");
        chk_value("je_taken.pc_abs", 64'(pc), 64'h100);
        step(0, 0, 0, 0, 0, 0, 0, "je_after");
        step(0, 0, 0, 1, 0, 0, 0, "we_eq0");
        step(1, 32'h100, 0, 0, 0, 0, 0, "je_not");

        // Same-cycle flag write must not affect the jump
        step(1, 32'h200, 0, 1, 1, 0, 0, "je_same_cycle");
        step(1, 32'h200, 0, 0, 0, 0, 0, "je_next");

        // pc wrap
        step(9, 32'h1FFFFF, 0, 0, 0, 0, 0, "jmp_max");
        step(0, 0, 0, 0, 0, 0, 0, "wrap");
        chk_value("wrap.pc_abs", 64'(pc), 64'h0);

        // Halt at pc 7, then JMPs are ignored
        step(9, 7, 0, 0, 0, 0, 0, "jmp7");
        step(10, 0, 0, 0, 0, 0, 0, "hlt");
        for (int i = 0; i < 20; i++) step(9, 32'h55, 0, 1, 1, 1, 1, "halted");
        chk_value("halted.pc_abs", 64'(pc), 64'd7);
        apply_reset("rst_halt");

        // Stall during JMP
        for (int i = 0; i < 3; i++) step(9, 32'h42, 1, 1, 1, 1, 1, "stall");
        step(9, 32'h42, 0, 0, 0, 0, 0, "unstall");
        chk_value("unstall.pc_abs", 64'(pc), 64'h42);

        // Counter saturation
        for (int i = 0; i < 260; i++) step(0, 0, 0, 0, 0, 0, 0, "sat");
        chk_value("sat.icount_abs", 64'(icount), 64'hFF);
        apply_reset("rst_sat");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) code = 10;
            else begin
                code = $urandom_range(0, 15);
                if (code == 10) code = 9;
            end
            step(code, $urandom, ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), "rand");
            if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0)
                apply_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
